// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, occupancy and flag control for a synchronous FIFO
// built around an external dual-port RAM with registered read data.
//
// Ports:
//   clk_i, rstn_i          single clock, async active-low reset
//   push_i, push_data_i    producer request and data
//   pop_i                  consumer request
//   pop_data_o, pop_valid_o read data, valid one cycle after an accepted pop
//   full_o, empty_o, almost_full_o, count_o   status
//   mem_w*_o, mem_r*_o, mem_rdata_i           RAM write/read ports
//
// Optional build macro SYNC_FIFO_ERR_EN adds sticky overflow_o/underflow_o.
module sync_fifo_ctrl #(
   parameter int AW       = 7,
   parameter int DW       = 32,
   parameter int DEPTH    = 128,
   parameter int AFULL_TH = 120
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] pop_data_o,
   output logic          pop_valid_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          almost_full_o,
   output logic [AW:0]   count_o,
   output logic          mem_wenable_o,
   output logic [AW-1:0] mem_waddr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_renable_o,
   output logic [AW-1:0] mem_raddr_o,
   input  logic [DW-1:0] mem_rdata_i
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic          overflow_o,
   output logic          underflow_o
`endif
);

   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] AFULL_C = AFULL_TH[AW:0];

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [AW:0] count_n;
   logic        push_acc;
   logic        pop_acc;

   // Acceptance uses the registered flags, so a simultaneous pop never
   // frees space for a push in the same cycle (and vice versa).
   assign push_acc = push_i & ~full_o;
   assign pop_acc  = pop_i & ~empty_o;

   assign mem_wenable_o = push_acc;
   assign mem_waddr_o   = wptr[AW-1:0];
   assign mem_wdata_o   = push_data_i;
   assign mem_renable_o = pop_acc;
   assign mem_raddr_o   = rptr[AW-1:0];

   // RAM holds its output register between reads, so data stays stable.
   assign pop_data_o = mem_rdata_i;

   always_comb begin
      count_n = count_o;
      unique case ({push_acc, pop_acc})
         2'b10:   count_n = count_o + 1'b1;
         2'b01:   count_n = count_o - 1'b1;
         default: count_n = count_o;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr          <= '0;
         rptr          <= '0;
         count_o       <= '0;
         full_o        <= 1'b0;
         empty_o       <= 1'b1;
         almost_full_o <= 1'b0;
         pop_valid_o   <= 1'b0;
      end else begin
         if (push_acc) wptr <= wptr + 1'b1;
         if (pop_acc)  rptr <= rptr + 1'b1;
         count_o       <= count_n;
         full_o        <= (count_n == DEPTH_C);
         empty_o       <= (count_n == '0);
         almost_full_o <= (count_n >= AFULL_C);
         pop_valid_o   <= pop_acc;
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (push_i & full_o)  overflow_o  <= 1'b1;
         if (pop_i & empty_o)  underflow_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: randomized scoreboard bench for sync_fifo_ctrl with a
// behavioural RAM and a queue-based reference model.
module tb_sync_fifo_ctrl;

   localparam int AW    = 7;
   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int AFTH  = 120;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          push_i = 1'b0;
   logic [DW-1:0] push_data_i = '0;
   logic          pop_i = 1'b0;
   logic [DW-1:0] pop_data_o;
   logic          pop_valid_o;
   logic          full_o;
   logic          empty_o;
   logic          almost_full_o;
   logic [AW:0]   count_o;
   logic          mem_wenable_o;
   logic [AW-1:0] mem_waddr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_renable_o;
   logic [AW-1:0] mem_raddr_o;
   logic [DW-1:0] mem_rdata_i = '0;
`ifdef SYNC_FIFO_ERR_EN
   logic          overflow_o;
   logic          underflow_o;
`endif

   sync_fifo_ctrl #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFTH)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .push_i(push_i),
      .push_data_i(push_data_i),
      .pop_i(pop_i),
      .pop_data_o(pop_data_o),
      .pop_valid_o(pop_valid_o),
      .full_o(full_o),
      .empty_o(empty_o),
      .almost_full_o(almost_full_o),
      .count_o(count_o),
      .mem_wenable_o(mem_wenable_o),
      .mem_waddr_o(mem_waddr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_renable_o(mem_renable_o),
      .mem_raddr_o(mem_raddr_o),
      .mem_rdata_i(mem_rdata_i)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .overflow_o(overflow_o),
      .underflow_o(underflow_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk_i) begin
      if (mem_wenable_o) ram[mem_waddr_o] <= mem_wdata_o;
      if (mem_renable_o) mem_rdata_i <= ram[mem_raddr_o];
   end

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_q[$];
   int  wcnt = 0;
   int  rcnt = 0;
   bit  ovf_m = 0;
   bit  unf_m = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (rstn_i && pop_valid_o) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
         else chk("pop_data", pop_data_o, exp_q.pop_front());
      end
   end

   task automatic status_chk();
      chk("count", count_o, q.size());
      chk("empty", empty_o, q.size() == 0);
      chk("full", full_o, q.size() == DEPTH);
      chk("afull", almost_full_o, q.size() >= AFTH);
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", overflow_o, ovf_m);
      chk("underflow", underflow_o, unf_m);
`endif
   endtask

   // Starts and ends on a falling edge.
   task automatic cycle(input bit p, input logic [DW-1:0] d, input bit r);
      bit pa;
      bit ra;
      push_i = p;
      push_data_i = d;
      pop_i = r;
      pa = p && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (p && q.size() == DEPTH) ovf_m = 1;
      if (r && q.size() == 0) unf_m = 1;
      #1;
      chk("wen", mem_wenable_o, pa);
      chk("ren", mem_renable_o, ra);
      if (pa) begin
         chk("waddr", mem_waddr_o, wcnt % DEPTH);
         chk("wdata", mem_wdata_o, d);
      end
      if (ra) chk("raddr", mem_raddr_o, rcnt % DEPTH);
      if (ra) begin
         exp_q.push_back(q.pop_front());
         rcnt++;
      end
      if (pa) begin
         q.push_back(d);
         wcnt++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      push_i = 0;
      pop_i = 0;
      chk("pop_valid", pop_valid_o, ra);
      status_chk();
   endtask

   initial begin
      rstn_i = 0;
      repeat (2) @(negedge clk_i);
      rstn_i = 1;
      @(negedge clk_i);
      status_chk();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0);

      for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0);
      chk("full_after_fill", full_o, 1);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1);
      cycle(0, 0, 0);
      chk("empty_after_drain", empty_o, 1);

      for (int i = 0; i < DEPTH; i++) cycle(1, $urandom, 0);
      cycle(1, 32'hDEADBEEF, 1);
      chk("count_full_pushpop", count_o, DEPTH - 1);
      while (q.size() > 0) cycle(0, 0, 1);
      cycle(0, 0, 0);

      cycle(1, 32'hA5A5A5A5, 1);
      chk("count_empty_pushpop", count_o, 1);
      cycle(0, 0, 1);
      cycle(0, 0, 0);

      for (int i = 0; i < AFTH - 1; i++) cycle(1, $urandom, 0);
      chk("afull_119", almost_full_o, 0);
      cycle(1, $urandom, 0);
      chk("afull_120", almost_full_o, 1);

      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1));

      while (q.size() > 50) cycle(0, 0, 1);
      while (q.size() < 50) cycle(1, $urandom, 0);
      chk("count_50", count_o, 50);

      pop_i = 1;
      exp_q.push_back(q.pop_front());
      @(posedge clk_i);
      #1 rstn_i = 0;
      pop_i = 0;
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_pop_valid", pop_valid_o, 0);
      q.delete();
      exp_q.delete();
      wcnt = 0;
      rcnt = 0;
      ovf_m = 0;
      unf_m = 0;
      @(posedge clk_i);
      #1 rstn_i = 1;
      @(negedge clk_i);
      status_chk();

      cycle(1, 32'h12345678, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
